// File: rtl/stickit_arb.sv
// Two-requester arbiter feeding the StickIt LED-digit scanner: captures one DATA value, then holds it HOLD_CYCLES cycles.
// Optional macro STICKIT_ARB_PRIO_EN gives requester 0 strict priority on ties instead of round-robin.
module stickit_arb #(
  parameter int unsigned HOLD_CYCLES = 1000000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        REQ0,
  input  logic [31:0] DATA0,
  output logic        GNT0,
  input  logic        REQ1,
  input  logic [31:0] DATA1,
  output logic        GNT1,
  output logic [31:0] VALUE,
  output logic        BUSY
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 2);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      value_q, value_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             busy_q;
  logic             pick1;

`ifdef STICKIT_ARB_PRIO_EN
  assign pick1 = REQ1 && !REQ0;
`else
  // last_q = 1 means requester 1 was granted most recently.
  logic last_q, last_d;
  assign pick1 = REQ1 && (!REQ0 || !last_q);
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      value_q <= 32'h0000_0000;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifndef STICKIT_ARB_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      busy_q  <= (state_d == HOLD);
`ifndef STICKIT_ARB_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  // Next-state, capture and hold-countdown logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
`ifndef STICKIT_ARB_PRIO_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (REQ0 || REQ1) begin
          state_d = HOLD;
          cnt_d   = CNT_LOAD;
          if (pick1) begin
            value_d = DATA1;
            gnt1_d  = 1'b1;
          end else begin
            value_d = DATA0;
            gnt0_d  = 1'b1;
          end
`ifndef STICKIT_ARB_PRIO_EN
          last_d = pick1;
`endif
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign GNT0  = gnt0_q;
  assign GNT1  = gnt1_q;
  assign VALUE = value_q;
  assign BUSY  = busy_q;

endmodule
